score_video_to_segments: RTL

SCORE_VIDEO_TO_SEGMENTS -- requirements
Module: score_video_to_segments

---
 rtl/score_video_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 22 ++
 rtl/score_video_to_segments.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/score_video_pkg.sv
// Shared definitions for recovering a 7-segment digit from score video:
// segment indices, sample-block geometry, legal digit patterns and FSM states.
package score_video_pkg;

    localparam int SEG_A      = 0;
    localparam int SEG_B      = 1;
    localparam int SEG_C      = 2;
    localparam int SEG_D      = 3;
    localparam int SEG_E      = 4;
    localparam int SEG_F      = 5;
    localparam int SEG_G      = 6;
    localparam int NUM_SEG    = 7;
    // Accumulator bit that collects lit pixels in the cell interior.
    localparam int GLITCH_BIT = 7;

    // Sample block of each segment, indexed by segment (element 0 = a).
    //                                      g     f     e     d     c     b     a
    localparam logic [6:0][2:0] SEG_ROW = {3'd3, 3'd1, 3'd5, 3'd7, 3'd5, 3'd1, 3'd0};
    localparam logic [6:0][1:0] SEG_COL = {2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd1};

    // Legal patterns (bit0 = a); 6 and 9 appear in tailed and tail-less forms.
    localparam int NUM_PAT = 12;
    localparam logic [NUM_PAT-1:0][6:0] DIGIT_PAT = {
        7'h67, 7'h6F, 7'h7F, 7'h07, 7'h7C, 7'h7D,
        7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [NUM_PAT-1:0][3:0] DIGIT_VAL = {
        4'd9, 4'd9, 4'd8, 4'd7, 4'd6, 4'd6,
        4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
    };

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Interior of the cell: middle two columns, rows away from the a/g/d bars.
    function automatic logic is_interior(input logic [2:0] row, input logic [1:0] col);
        logic col_mid;
        logic row_mid;
        col_mid = (col == 2'd1) || (col == 2'd2);
        row_mid = (row == 3'd1) || (row == 3'd2) || (row == 3'd4) ||
                  (row == 3'd5) || (row == 3'd6);
        return col_mid && row_mid;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup from a 7-segment pattern to its digit value.
module seg7_decode
    import score_video_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] digit,
    output logic       ok
);

    // Scan the legal-pattern table; no match leaves ok low.
    always_comb begin
        digit = 4'd0;
        ok    = 1'b0;
        for (int i = 0; i < NUM_PAT; i++) begin
            if (pat == DIGIT_PAT[i]) begin
                digit = DIGIT_VAL[i];
                ok    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_video_to_segments.sv
// Watches one digit cell of the score video, accumulates which segments are
// lit each frame and publishes the digit once two consecutive frames agree.
module score_video_to_segments
    import score_video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       h4,
    input  logic       h8,
    input  logic       h16,
    input  logic       v4,
    input  logic       v8,
    input  logic       v16,
    input  logic       digit_win,
    input  logic       vblank,
    input  logic       score,
    output logic [6:0] seg,
    output logic [3:0] digit,
    output logic       digit_ok,
    output logic       glitch,
    output logic       upd
);

    state_e     state_q, state_d;
    logic       vblank_q, vblank_d;
    logic [7:0] acc_q, acc_d;      // {glitch, g..a} for the frame in progress
    logic [7:0] prev_q, prev_d;    // last committed frame
    logic [1:0] cnt_q, cnt_d;      // consecutive-equal-frame count, saturates at 2
    logic       pend_q, pend_d;    // outputs take prev_q on the next cycle
    logic [6:0] seg_q, seg_d;
    logic [3:0] digit_q, digit_d;
    logic       digit_ok_q, digit_ok_d;
    logic       glitch_q, glitch_d;
    logic       upd_q, upd_d;

    logic       vb_rise, vb_fall, cell_active;
    logic [1:0] col;
    logic [2:0] row;
    logic [7:0] hit;
    logic [3:0] dec_digit;
    logic       dec_ok;

    assign vblank_d    = vblank;
    assign vb_rise     = vblank & ~vblank_q;
    assign vb_fall     = ~vblank & vblank_q;
    assign cell_active = digit_win & h16;
    assign col         = {h8, h4};
    assign row         = {v16, v8, v4};

    // Committed frame is stable in prev_q while the outputs are loaded.
    seg7_decode u_decode (
        .pat   (prev_q[6:0]),
        .digit (dec_digit),
        .ok    (dec_ok)
    );

    // Which accumulator bits the current raster position belongs to.
    always_comb begin
        hit = 8'd0;
        for (int i = 0; i < NUM_SEG; i++) begin
            hit[i] = (row == SEG_ROW[i]) && (col == SEG_COL[i]);
        end
        hit[GLITCH_BIT] = is_interior(row, col);
    end

    // Frame FSM, stability counter and output update.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        pend_d     = 1'b0;
        seg_d      = seg_q;
        digit_d    = digit_q;
        digit_ok_d = digit_ok_q;
        glitch_d   = glitch_q;
        upd_d      = 1'b0;

        case (state_q)
            ST_WAIT: begin
                // A rising vblank here has no frame behind it and is ignored.
                if (vb_fall) begin
                    acc_d   = 8'd0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (pix_ce && cell_active && score) begin
                    acc_d = acc_q | hit;
                end
                if (vb_rise) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (acc_q == prev_q) begin
                    cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
                end else begin
                    cnt_d = 2'd1;
                end
                prev_d  = acc_q;
                pend_d  = (cnt_d == 2'd2) && (acc_q != {glitch_q, seg_q});
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase

        if (pend_q) begin
            seg_d      = prev_q[6:0];
            glitch_d   = prev_q[GLITCH_BIT];
            digit_ok_d = dec_ok;
            if (dec_ok) begin
                digit_d = dec_digit;
            end
            upd_d = 1'b1;
        end
    end

    // vblank history runs every clock so edges are never missed or invented by reset.
    always_ff @(posedge clk) begin
        vblank_q <= vblank_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            acc_q      <= 8'd0;
            prev_q     <= 8'd0;
            cnt_q      <= 2'd0;
            pend_q     <= 1'b0;
            seg_q      <= 7'd0;
            digit_q    <= 4'd0;
            digit_ok_q <= 1'b0;
            glitch_q   <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
            digit_ok_q <= digit_ok_d;
            glitch_q   <= glitch_d;
            upd_q      <= upd_d;
        end
    end

    assign seg      = seg_q;
    assign digit    = digit_q;
    assign digit_ok = digit_ok_q;
    assign glitch   = glitch_q;
    assign upd      = upd_q;

endmodule
